// File: rtl/mac_seq_ctrl_if.sv
// Operand/result handshake bundle for the multiply-accumulate sequencer.
// The master side is the operand source plus result consumer; the slave
// side is the controller itself.
interface mac_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clear_acc;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             busy;
  logic             overflow;

  modport master (
    output in_valid, a, b, clear_acc, out_ready,
    input  in_ready, out_valid, acc_out, busy, overflow
  );

  modport slave (
    input  in_valid, a, b, clear_acc, out_ready,
    output in_ready, out_valid, acc_out, busy, overflow
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for an unsigned multiply-accumulate unit.
// One operand pair per transaction: WIDTH shift-add cycles form the product,
// one cycle adds it into the accumulator through a chain of 4-bit CLA
// slices, then the result is held on a valid/ready output until taken.
module mac_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
) (
  input logic           clk,
  input logic           rst,
  mac_seq_ctrl_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NSL   = (ACC_W + 3) / 4;
  localparam int PAD_W = NSL * 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // The accumulator must be able to hold at least one full product.
  if (ACC_W < 2 * WIDTH) begin : g_bad_cfg
    $fatal(1, "mac_seq_ctrl: ACC_W must be >= 2*WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // 4-bit carry-lookahead slice: returns {cout, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             clr_q, clr_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             in_ready_s;
  logic [PW-1:0]    addend_s;
  logic [PAD_W-1:0] add_a_s;
  logic [PAD_W-1:0] add_b_s;
  logic [PAD_W-1:0] add_sum_s;
  logic [NSL:0]     carry_s;
  logic [4:0]       slice_s;
  logic [PAD_W:0]   full_sum_s;
  logic             acc_carry_s;

  // Status outputs are pure decodes of the state register or register copies.
  assign in_ready_s    = (state_q == S_IDLE);
  assign bus.in_ready  = in_ready_s;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;

  // Multiplicand aligned to the current partial-product bit position.
  assign addend_s = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

  // Accumulate adder: chained CLA slices, carry-in 0, operands zero-padded.
  always_comb begin
    add_a_s            = '0;
    add_b_s            = '0;
    add_sum_s          = '0;
    carry_s            = '0;
    slice_s            = '0;
    add_a_s[ACC_W-1:0] = clr_q ? {ACC_W{1'b0}} : acc_q;
    add_b_s[PW-1:0]    = prod_q;
    for (int s = 0; s < NSL; s++) begin
      slice_s             = cla4(add_a_s[4*s +: 4], add_b_s[4*s +: 4], carry_s[s]);
      add_sum_s[4*s +: 4] = slice_s[3:0];
      carry_s[s+1]        = slice_s[4];
    end
  end

  // Bit ACC_W of the padded sum is the top slice cout when ACC_W fills the slices.
  assign full_sum_s  = {carry_s[NSL], add_sum_s};
  assign acc_carry_s = full_sum_s[ACC_W];

  // Next-state and datapath update for the IDLE->MULT->ACC->DONE sequence.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    clr_d    = clr_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_s) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          clr_d    = bus.clear_acc;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_MULT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_MULT: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + addend_s;
        end else begin
          prod_d = prod_q;
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_ACC;
        end else begin
          state_d = S_MULT;
        end
      end
      S_ACC: begin
        acc_d   = full_sum_s[ACC_W-1:0];
        ovf_d   = clr_q ? acc_carry_s : (ovf_q | acc_carry_s);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      clr_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      clr_q    <= clr_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
